// File: rtl/instr_scheduler_pkg.sv
// instr_scheduler_pkg: shared widths and FSM state type for the instruction scheduler
package instr_scheduler_pkg;
  localparam int INSTR_W = 32;
  localparam int REG_W = 10;
  localparam int DATA_W = 16;
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_READ_A,
    S_READ_D
  } state_e;
endpackage

// File: rtl/sched_fifo.sv
// sched_fifo: DEPTH x INSTR_W instruction queue with wrap-bit pointers for full/empty
module sched_fifo
  import instr_scheduler_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [INSTR_W-1:0] data_i,
  output logic [INSTR_W-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  // storage needs no reset; occupancy is defined by the pointers alone
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end
  // pointers carry one extra wrap bit to tell full from empty
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
    end
  end
  assign data_o = mem_q[rd_q[AW-1:0]];
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
endmodule

// File: rtl/instr_scheduler.sv
// instr_scheduler: queues host instructions, issues them to the array controller and serves readbacks
module instr_scheduler
  import instr_scheduler_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int DEPTH = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               host_valid,
  input  logic [INSTR_W-1:0] host_instr,
  output logic               host_ready,
  output logic [INSTR_W-1:0] ctrl_instruction,
  output logic               ctrl_start,
  input  logic               ctrl_done,
  input  logic               rd_req,
  input  logic [SIZE-1:0]    rd_pe,
  input  logic [REG_W-1:0]   rd_reg,
  output logic [SIZE-1:0]    pe_addr,
  output logic [REG_W-1:0]   reg_addr,
  input  logic [DATA_W-1:0]  arr_data,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic               err_timeout,
  output logic [CNT_W-1:0]   issued_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  state_e state_q, state_d;
  logic full, empty, push, pop, grant_issue, grant_read, done_rise, tmo_hit;
  logic done_q, pri_read_q, err_q;
  logic [INSTR_W-1:0] head, instr_q;
  logic [SIZE-1:0] pe_q;
  logic [REG_W-1:0] reg_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TW-1:0] tmo_q;

  sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push_i(push),
    .pop_i(pop),
    .data_i(host_instr),
    .data_o(head),
    .full_o(full),
    .empty_o(empty)
  );

  assign push = host_valid && !full;
  assign host_ready = !full;
  assign grant_issue = !empty && (!rd_req || !pri_read_q);
  assign grant_read = rd_req && (empty || pri_read_q);
  assign pop = (state_q == S_IDLE) && grant_issue;
  assign done_rise = ctrl_done && !done_q;
  assign tmo_hit = tmo_q == TMO_LAST;
  assign ctrl_instruction = instr_q;
  assign pe_addr = pe_q;
  assign reg_addr = reg_q;
  assign rd_data = data_q;
  assign err_timeout = err_q;
  assign issued_cnt = cnt_q;

  // state register
  always_ff @(posedge clk) begin
    state_q <= reset ? S_IDLE : state_d;
  end
  // next state: IDLE arbitrates, WAIT exits on completion or timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = grant_issue ? S_ISSUE : grant_read ? S_READ_A : S_IDLE;
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT:   state_d = (done_rise || tmo_hit) ? S_IDLE : S_WAIT;
      S_READ_A: state_d = S_READ_D;
      default:  state_d = S_IDLE;
    endcase
  end
  // state-decoded outputs
  always_comb begin
    ctrl_start = state_q == S_ISSUE;
    rd_valid = state_q == S_READ_D;
    busy = (state_q != S_IDLE) || !empty;
  end
  // datapath: grant latching, completion tracking, timeout and readback capture
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pe_q <= '0;
      reg_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      pri_read_q <= 1'b0;
      done_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      done_q <= ctrl_done;
      tmo_q <= (state_q == S_WAIT) ? tmo_q + 1'b1 : '0;
      if (state_q == S_IDLE && grant_issue) begin
        instr_q <= head;
        pri_read_q <= 1'b1;
      end
      if (state_q == S_IDLE && grant_read) begin
        pe_q <= rd_pe;
        reg_q <= rd_reg;
        pri_read_q <= 1'b0;
      end
      if (state_q == S_WAIT && done_rise) cnt_q <= cnt_q + 1'b1;
      else if (state_q == S_WAIT && tmo_hit) err_q <= 1'b1;
      if (state_q == S_READ_A) data_q <= arr_data;
    end
  end
endmodule
